// File: rtl/mano_memory.sv
// -----------------------------------------------------------------------------
// mano_memory
//
// Unified 2^ADDR_W x 16 main memory for the Mano machine core, fronted by a
// byte-stream program loader.
//
// After reset the loader accepts program bytes (high byte of each word first),
// packs them big-endian into 16-bit words and writes them from address 0
// upward while cpu_run holds the CPU stalled. The low byte qualified by
// ld_last ends the load. From then on the block serves the CPU memory port:
// combinational read, synchronous write. The block leaves RUN only on reset.
//
// Optional feature (macro MANO_MEM_WP_EN):
//   Write protection of the loaded program region. In RUN a CPU write whose
//   word address is below load_words is dropped, and wp_hit pulses for the
//   cycle after that edge. Without the macro every RUN write executes and
//   wp_hit stays 0.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   ld_valid   in   loader byte valid
//   ld_ready   out  loader can accept a byte (combinational from state)
//   ld_byte    in   program byte, high byte of each word first
//   ld_last    in   final byte of the program (honoured on a low byte only)
//   cpu_run    out  CPU enable, 1 once the program has been loaded
//   cpu_addr   in   CPU word address (AR); only [ADDR_W-1:0] is used
//   cpu_wdata  in   CPU write data
//   cpu_we_n   in   CPU write strobe, active-low
//   cpu_rdata  out  mem[cpu_addr[ADDR_W-1:0]], combinational in every state
//   load_words out  number of words written by the loader, saturating
//   wp_hit     out  write-protect violation pulse
// -----------------------------------------------------------------------------
module mano_memory #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              cpu_run,
    input  logic [15:0]       cpu_addr,
    input  logic [15:0]       cpu_wdata,
    input  logic              cpu_we_n,
    output logic [15:0]       cpu_rdata,
    output logic [ADDR_W:0]   load_words,
    output logic              wp_hit
);

    localparam int DEPTH = 1 << ADDR_W;

    // Saturation value of the word counter: exactly 2^ADDR_W.
    localparam logic [ADDR_W:0]   WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   WORDS_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_LOAD_HI = 2'b00,
        ST_LOAD_LO = 2'b01,
        ST_RUN     = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ADDR_W-1:0]  ptr_r;
    logic [ADDR_W-1:0]  ptr_nxt_s;
    logic [7:0]         hi_q_r;
    logic [7:0]         hi_q_nxt_s;
    logic [ADDR_W:0]    load_words_r;
    logic [ADDR_W:0]    load_words_nxt_s;
    logic               wp_hit_r;
    logic               wp_hit_nxt_s;

    logic               accept_s;
    logic               ld_ready_s;
    logic [ADDR_W-1:0]  cpu_idx_s;
    logic               wp_block_s;

    logic               mem_we_s;
    logic [ADDR_W-1:0]  mem_waddr_s;
    logic [15:0]        mem_wdata_s;

    logic [15:0]        mem_r [0:DEPTH-1];

    // Upper address bits are architecturally ignored (aliasing); fold them
    // into a sink so the intent is explicit.
    logic               addr_hi_unused_s;
    assign addr_hi_unused_s = ^cpu_addr[15:ADDR_W];

    assign cpu_idx_s  = cpu_addr[ADDR_W-1:0];
    assign ld_ready_s = (state_r == ST_LOAD_HI) || (state_r == ST_LOAD_LO);
    assign accept_s   = ld_valid & ld_ready_s;

`ifdef MANO_MEM_WP_EN
    // The loaded program occupies [0, load_words); a full-depth load
    // (load_words = 2^ADDR_W) therefore protects every address.
    assign wp_block_s = ({1'b0, cpu_idx_s} < load_words_r);
`else
    assign wp_block_s = 1'b0;
`endif

    // Next-state, loader datapath and memory write-port selection.
    always_comb begin
        state_nxt_s      = state_r;
        ptr_nxt_s        = ptr_r;
        hi_q_nxt_s       = hi_q_r;
        load_words_nxt_s = load_words_r;
        wp_hit_nxt_s     = 1'b0;
        mem_we_s         = 1'b0;
        mem_waddr_s      = ptr_r;
        mem_wdata_s      = {hi_q_r, ld_byte};

        case (state_r)
            ST_LOAD_HI: begin
                // ld_last is deliberately ignored on a high byte.
                if (accept_s) begin
                    hi_q_nxt_s  = ld_byte;
                    state_nxt_s = ST_LOAD_LO;
                end else begin
                    state_nxt_s = ST_LOAD_HI;
                end
            end
            ST_LOAD_LO: begin
                if (accept_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = ptr_r;
                    mem_wdata_s = {hi_q_r, ld_byte};
                    // Pointer wraps naturally; later words overwrite earlier.
                    ptr_nxt_s   = ptr_r + PTR_ONE;
                    if (load_words_r != WORDS_MAX) begin
                        load_words_nxt_s = load_words_r + WORDS_ONE;
                    end else begin
                        load_words_nxt_s = load_words_r;
                    end
                    if (ld_last) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_LOAD_HI;
                    end
                end else begin
                    state_nxt_s = ST_LOAD_LO;
                end
            end
            ST_RUN: begin
                // Loader is inert; only the CPU port writes memory.
                if (!cpu_we_n) begin
                    if (wp_block_s) begin
                        wp_hit_nxt_s = 1'b1;
                    end else begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = cpu_idx_s;
                        mem_wdata_s = cpu_wdata;
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
                state_nxt_s = ST_RUN;
            end
            default: begin
                // Unreachable encoding: restart the load cleanly.
                state_nxt_s = ST_LOAD_HI;
            end
        endcase
    end

    // Loader / control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_LOAD_HI;
            ptr_r        <= {ADDR_W{1'b0}};
            hi_q_r       <= 8'h00;
            load_words_r <= {(ADDR_W+1){1'b0}};
            wp_hit_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            ptr_r        <= ptr_nxt_s;
            hi_q_r       <= hi_q_nxt_s;
            load_words_r <= load_words_nxt_s;
            wp_hit_r     <= wp_hit_nxt_s;
        end
    end

    // Memory array write port; contents are intentionally not reset so that
    // words already loaded survive a reset until overwritten.
    always_ff @(posedge clk) begin
        if (mem_we_s && reset_n) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Zero-wait-state read: the CPU samples this in the same cycle AR changes.
    assign cpu_rdata  = mem_r[cpu_idx_s];

    assign ld_ready   = ld_ready_s;
    assign cpu_run    = (state_r == ST_RUN);
    assign load_words = load_words_r;
    assign wp_hit     = wp_hit_r;

endmodule

// File: tb/tb_mano_memory.sv
module tb_mano_memory;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              reset_n;
    logic              ld_valid;
    logic              ld_ready;
    logic [7:0]        ld_byte;
    logic              ld_last;
    logic              cpu_run;
    logic [15:0]       cpu_addr;
    logic [15:0]       cpu_wdata;
    logic              cpu_we_n;
    logic [15:0]       cpu_rdata;
    logic [ADDR_W:0]   load_words;
    logic              wp_hit;

    mano_memory #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_byte    (ld_byte),
        .ld_last    (ld_last),
        .cpu_run    (cpu_run),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we_n   (cpu_we_n),
        .cpu_rdata  (cpu_rdata),
        .load_words (load_words),
        .wp_hit     (wp_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MANO_MEM_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [7:0]  b;
        logic        last;
        logic        exp_ready;
        logic        exp_run;
        logic [12:0] exp_words;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic sb_push(input logic [15:0] a, input logic [15:0] d);
        sb_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic send_word(input logic [15:0] a, input logic [15:0] w, input logic last);
        send_byte(w[15:8], 1'b0);
        send_byte(w[7:0], last);
        sb_push(a, w);
    endtask

    task automatic drain_sb(input string name);
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cpu_addr = e.addr;
            #1;
            check(name, cpu_rdata, e.data);
        end
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [15:0] d);
        cpu_addr = a;
        #1;
        check(name, cpu_rdata, d);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we_n  = 1'b0;
        @(posedge clk);
        #1;
        cpu_we_n  = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the whole run is a few thousand cycles.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        logic [15:0] gap_words[3];

        vecs[0] = '{8'h72, 1'b0, 1'b1, 1'b0, 13'd0};
        vecs[1] = '{8'h00, 1'b0, 1'b1, 1'b0, 13'd1};
        vecs[2] = '{8'h10, 1'b0, 1'b1, 1'b0, 13'd1};
        vecs[3] = '{8'h23, 1'b1, 1'b0, 1'b1, 13'd2};
        gap_words[0] = 16'h0A0B;
        gap_words[1] = 16'hC0DE;
        gap_words[2] = 16'h5A5A;

        reset_n   = 1'b0;
        ld_valid  = 1'b0;
        ld_byte   = 8'h00;
        ld_last   = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 16'h0000;
        cpu_we_n  = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cpu_run", cpu_run, 1'b0);
        check("rst_load_words", load_words, 13'd0);
        check("rst_wp_hit", wp_hit, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ld_ready", ld_ready, 1'b1);

        // Basic 2-word load, table driven
        for (int i = 0; i < 4; i++) begin
            send_byte(vecs[i].b, vecs[i].last);
            check($sformatf("vec%0d_ready", i), ld_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_run", i), cpu_run, vecs[i].exp_run);
            check($sformatf("vec%0d_words", i), load_words, vecs[i].exp_words);
        end
        sb_push(16'h0000, 16'h7200);
        sb_push(16'h0001, 16'h1023);
        drain_sb("basic_mem");

        // Loader inert in RUN
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b1);
        check("run_inert_words", load_words, 13'd2);
        check("run_inert_run", cpu_run, 1'b1);
        read_check("run_inert_mem0", 16'h0000, 16'h7200);
        read_check("run_inert_mem1", 16'h0001, 16'h1023);

        // CPU write / read-during-write / aliasing
        cpu_write(16'h0F00, 16'h1111);
        @(negedge clk);
        cpu_addr  = 16'h0F00;
        cpu_wdata = 16'hBEEF;
        cpu_we_n  = 1'b0;
        #1;
        check("rdw_old", cpu_rdata, 16'h1111);
        @(posedge clk);
        #1;
        check("rdw_new", cpu_rdata, 16'hBEEF);
        cpu_we_n = 1'b1;
        read_check("alias_ff00", 16'hFF00, 16'hBEEF);

        // Reset mid-load after 3 bytes; CPU writes ignored during load
        do_reset();
        check("rst2_run", cpu_run, 1'b0);
        check("rst2_words", load_words, 13'd0);
        check("rst2_ready", ld_ready, 1'b1);
        cpu_addr  = 16'h0F00;
        cpu_wdata = 16'hDEAD;
        cpu_we_n  = 1'b0;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        check("mid_words", load_words, 13'd1);
        do_reset();
        check("rst3_run", cpu_run, 1'b0);
        check("rst3_words", load_words, 13'd0);
        check("rst3_ready", ld_ready, 1'b1);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        cpu_we_n = 1'b1;
        check("reload_words", load_words, 13'd1);
        check("reload_run", cpu_run, 1'b1);
        read_check("reload_mem0", 16'h0000, 16'h1234);
        read_check("load_ignores_cpu_we", 16'h0F00, 16'hBEEF);

        // Random ld_valid gaps during a 3-word load
        do_reset();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 2; k++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    ld_valid = 1'b0;
                    ld_byte  = 8'($urandom);
                    ld_last  = 1'($urandom);
                end
                w = gap_words[i];
                send_byte(k == 0 ? w[15:8] : w[7:0], (k == 1) && (i == 2));
            end
            sb_push(16'(i), gap_words[i]);
        end
        check("gap_words", load_words, 13'd3);
        check("gap_run", cpu_run, 1'b1);
        drain_sb("gap_mem");

        // ld_last on a high byte is ignored
        do_reset();
        send_byte(8'hAB, 1'b1);
        check("hi_last_ready", ld_ready, 1'b1);
        check("hi_last_run", cpu_run, 1'b0);
        check("hi_last_words", load_words, 13'd0);
        send_byte(8'hCD, 1'b1);
        check("lo_last_run", cpu_run, 1'b1);
        check("lo_last_words", load_words, 13'd1);
        read_check("lo_last_mem0", 16'h0000, 16'hABCD);

        // Write protection (or plain writes without the macro)
        do_reset();
        send_word(16'h0000, 16'h1111, 1'b0);
        send_word(16'h0001, 16'h2222, 1'b1);
        drain_sb("wp_load_mem");
        cpu_write(16'h0001, 16'h5555);
        check("wp1_hit", wp_hit, WP);
        read_check("wp1_mem1", 16'h0001, WP ? 16'h2222 : 16'h5555);
        @(posedge clk);
        #1;
        check("wp1_hit_clear", wp_hit, 1'b0);
        cpu_write(16'h0002, 16'h6666);
        check("wp2_hit", wp_hit, 1'b0);
        read_check("wp2_mem2", 16'h0002, 16'h6666);

        // Full-depth load plus one word: pointer wraps, counter saturates
        do_reset();
        for (int i = 0; i <= 4096; i++) begin
            w = 16'(i) ^ 16'hA5A5;
            send_byte(w[15:8], 1'b0);
            send_byte(w[7:0], i == 4096);
            if (i == 4095) begin
                check("full_words", load_words, 13'd4096);
                check("full_run", cpu_run, 1'b0);
            end
        end
        check("sat_words", load_words, 13'd4096);
        check("sat_run", cpu_run, 1'b1);
        read_check("wrap_mem0", 16'h0000, 16'h1000 ^ 16'hA5A5);
        read_check("wrap_mem1", 16'h0001, 16'h0001 ^ 16'hA5A5);
        read_check("wrap_mem4095", 16'h0FFF, 16'h0FFF ^ 16'hA5A5);
        cpu_write(16'h0FFF, 16'h7777);
        check("sat_wp_hit", wp_hit, WP);
        read_check("sat_wp_mem", 16'h0FFF, WP ? (16'h0FFF ^ 16'hA5A5) : 16'h7777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
